// File: rtl/meta_pkg.sv
// Shared types and default parameter values for the meta_ajuste setpoint block.
package meta_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_VAL_MIN  = 0;
  localparam int DEF_VAL_MAX  = 99;
  localparam int DEF_VAL_INIT = 25;
  localparam int DEF_LOCKOUT  = 4;

endpackage

// File: rtl/meta_ajuste_if.sv
// Strobe inputs and setpoint outputs of meta_ajuste; slave is the setpoint side.
interface meta_ajuste_if #(
  parameter int WIDTH = 8
);
  logic             aumentar;
  logic             disminuir;
  logic [WIDTH-1:0] meta;
  logic             cambio;
  logic             limite;

  modport master (output aumentar, output disminuir, input meta, input cambio, input limite);
  modport slave  (input aumentar, input disminuir, output meta, output cambio, output limite);
endinterface

// File: rtl/detector_flanco.sv
// Falling-edge detector for an active-low strobe; history resets high so a strobe
// held low through reset release is reported on the first edge afterwards.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic strobe_n,
  output logic evento
);

  logic hist;

  always_ff @(posedge clk) begin
    if (reset) hist <= 1'b1;
    else       hist <= strobe_n;
  end

  assign evento = hist & ~strobe_n;

endmodule

// File: rtl/meta_ajuste.sv
// Bounded setpoint register driven by conditioned increase/decrease strobes.
// Define WRAP_EN to wrap at the bounds instead of saturating.
//
// state | meaning
// IDLE  | accepting strobe events
// LOCK  | post-strobe lockout, events ignored while the counter runs down
module meta_ajuste
  import meta_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int VAL_MIN  = DEF_VAL_MIN,
  parameter int VAL_MAX  = DEF_VAL_MAX,
  parameter int VAL_INIT = DEF_VAL_INIT,
  parameter int LOCKOUT  = DEF_LOCKOUT
) (
  input  logic          clk,
  input  logic          reset,
  meta_ajuste_if.slave  bus
);

  localparam int CW = (LOCKOUT < 1) ? 1 : $clog2(LOCKOUT + 1);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(VAL_MIN);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(VAL_MAX);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(VAL_INIT);
  localparam logic             LIM_INIT = (INIT_W == MIN_W) || (INIT_W == MAX_W);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] meta_q, meta_n;
  logic             cambio_q, cambio_n;
  logic             limite_q, limite_n;
  logic             ev_up, ev_dn;

  detector_flanco u_det_up (.clk(clk), .reset(reset), .strobe_n(bus.aumentar),  .evento(ev_up));
  detector_flanco u_det_dn (.clk(clk), .reset(reset), .strobe_n(bus.disminuir), .evento(ev_dn));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      meta_q   <= INIT_W;
      cambio_q <= 1'b0;
      limite_q <= LIM_INIT;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      meta_q   <= meta_n;
      cambio_q <= cambio_n;
      limite_q <= limite_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    meta_n  = meta_q;
    case (state)
      IDLE: begin
        // simultaneous events cancel out and do not start a lockout
        if (ev_up ^ ev_dn) begin
          if (ev_up) begin
            if (meta_q == MAX_W) begin
`ifdef WRAP_EN
              meta_n = MIN_W;
`else
              meta_n = meta_q;
`endif
            end else begin
              meta_n = meta_q + WIDTH'(1);
            end
          end else begin
            if (meta_q == MIN_W) begin
`ifdef WRAP_EN
              meta_n = MAX_W;
`else
              meta_n = meta_q;
`endif
            end else begin
              meta_n = meta_q - WIDTH'(1);
            end
          end
          if (LOCKOUT > 0) begin
            state_n = LOCK;
            cnt_n   = CW'(LOCKOUT);
          end
        end
      end
      LOCK: begin
        cnt_n = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
    endcase
    cambio_n = (meta_n != meta_q);
    limite_n = (meta_n == MIN_W) || (meta_n == MAX_W);
  end

  assign bus.meta   = meta_q;
  assign bus.cambio = cambio_q;
  assign bus.limite = limite_q;

endmodule

// File: tb/tb_meta_ajuste.sv
// Directed self-checking bench for meta_ajuste; main instance plus instances
// preloaded at the upper and lower bound. Expectations follow WRAP_EN.
module tb_meta_ajuste;
  import meta_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  meta_ajuste_if #(.WIDTH(8)) u ();
  meta_ajuste_if #(.WIDTH(8)) s ();
  meta_ajuste_if #(.WIDTH(8)) m ();

  meta_ajuste #(.WIDTH(8), .VAL_MIN(0), .VAL_MAX(99), .VAL_INIT(25), .LOCKOUT(4))
    dut (.clk(clk), .reset(reset), .bus(u));
  meta_ajuste #(.WIDTH(8), .VAL_MIN(0), .VAL_MAX(99), .VAL_INIT(99), .LOCKOUT(4))
    dut_sat (.clk(clk), .reset(reset), .bus(s));
  meta_ajuste #(.WIDTH(8), .VAL_MIN(0), .VAL_MAX(99), .VAL_INIT(0), .LOCKOUT(4))
    dut_min (.clk(clk), .reset(reset), .bus(m));

`ifdef WRAP_EN
  localparam int TOP_UP_META   = 0;
  localparam int TOP_UP_CAMBIO = 1;
  localparam int TOP_UP_LIM    = 1;
  localparam int TOP_DN_META   = 99;
  localparam int TOP_DN_LIM    = 1;
  localparam int BOT_DN_META   = 99;
  localparam int BOT_DN_CAMBIO = 1;
`else
  localparam int TOP_UP_META   = 99;
  localparam int TOP_UP_CAMBIO = 0;
  localparam int TOP_UP_LIM    = 1;
  localparam int TOP_DN_META   = 98;
  localparam int TOP_DN_LIM    = 0;
  localparam int BOT_DN_META   = 0;
  localparam int BOT_DN_CAMBIO = 0;
`endif

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    u.aumentar = 1'b1; u.disminuir = 1'b1;
    s.aumentar = 1'b1; s.disminuir = 1'b1;
    m.aumentar = 1'b1; m.disminuir = 1'b1;
    tick(2);
    chk("reset_meta",   32'(u.meta), 25);
    chk("reset_cambio", 32'(u.cambio), 0);
    chk("reset_limite", 32'(u.limite), 0);
    chk("reset_lim_top", 32'(s.limite), 1);
    chk("reset_lim_bot", 32'(m.limite), 1);

    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_meta",   32'(u.meta), 25);
      chk("idle_cambio", 32'(u.cambio), 0);
    end

    // single pulse
    u.aumentar = 1'b0; tick(1);
    chk("inc_meta",   32'(u.meta), 26);
    chk("inc_cambio", 32'(u.cambio), 1);
    u.aumentar = 1'b1; tick(1);
    chk("inc_cambio_drop", 32'(u.cambio), 0);
    tick(6);

    // held strobe counts once
    u.aumentar = 1'b0; tick(1);
    chk("hold_first", 32'(u.meta), 27);
    tick(19);
    chk("hold_meta",   32'(u.meta), 27);
    chk("hold_cambio", 32'(u.cambio), 0);
    u.aumentar = 1'b1; tick(6);

    // second pulse 3 edges later falls in the lockout
    u.aumentar = 1'b0; tick(1);
    chk("lock3_first", 32'(u.meta), 28);
    u.aumentar = 1'b1; tick(2);
    u.aumentar = 1'b0; tick(1);
    chk("lock3_ignored", 32'(u.meta), 28);
    chk("lock3_cambio",  32'(u.cambio), 0);
    u.aumentar = 1'b1; tick(6);

    // second pulse 5 edges later is accepted
    u.aumentar = 1'b0; tick(1);
    chk("lock5_first", 32'(u.meta), 29);
    u.aumentar = 1'b1; tick(4);
    u.aumentar = 1'b0; tick(1);
    chk("lock5_meta",   32'(u.meta), 30);
    chk("lock5_cambio", 32'(u.cambio), 1);
    u.aumentar = 1'b1; tick(6);

    // simultaneous events cancel, no lockout afterwards
    u.aumentar = 1'b0; u.disminuir = 1'b0; tick(1);
    chk("both_meta",   32'(u.meta), 30);
    chk("both_cambio", 32'(u.cambio), 0);
    u.aumentar = 1'b1; u.disminuir = 1'b1; tick(1);
    u.disminuir = 1'b0; tick(1);
    chk("after_both_meta",   32'(u.meta), 29);
    chk("after_both_cambio", 32'(u.cambio), 1);
    u.disminuir = 1'b1; tick(6);

    // reset in LOCK aborts the lockout
    u.aumentar = 1'b0; tick(1);
    chk("rstlock_first", 32'(u.meta), 30);
    u.aumentar = 1'b1; reset = 1'b1; tick(1);
    chk("rstlock_meta",   32'(u.meta), 25);
    chk("rstlock_cambio", 32'(u.cambio), 0);
    chk("rstlock_limite", 32'(u.limite), 0);
    reset = 1'b0; u.aumentar = 1'b0; tick(1);
    chk("rstlock_next",   32'(u.meta), 26);
    chk("rstlock_cambio2", 32'(u.cambio), 1);
    u.aumentar = 1'b1; tick(6);

    // bound behaviour on the preloaded instances
    chk("top_meta", 32'(s.meta), 99);
    s.aumentar = 1'b0; m.disminuir = 1'b0; tick(1);
    chk("top_up_meta",   32'(s.meta), TOP_UP_META);
    chk("top_up_cambio", 32'(s.cambio), TOP_UP_CAMBIO);
    chk("top_up_limite", 32'(s.limite), TOP_UP_LIM);
    chk("bot_dn_meta",   32'(m.meta), BOT_DN_META);
    chk("bot_dn_cambio", 32'(m.cambio), BOT_DN_CAMBIO);
    chk("bot_dn_limite", 32'(m.limite), 1);
    s.aumentar = 1'b1; m.disminuir = 1'b1; tick(1);
    // decrease inside the lockout is ignored even after saturation
    s.disminuir = 1'b0; tick(1);
    chk("top_lock_meta", 32'(s.meta), TOP_UP_META);
    s.disminuir = 1'b1; tick(3);
    s.disminuir = 1'b0; tick(1);
    chk("top_dn_meta",   32'(s.meta), TOP_DN_META);
    chk("top_dn_limite", 32'(s.limite), TOP_DN_LIM);
    chk("top_dn_cambio", 32'(s.cambio), 1);
    s.disminuir = 1'b1; tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
